// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// The optional single-cycle multiplier is selected with MULDIV_FAST_MUL_EN.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: magnitude accumulators, shift-add / restoring divide step
// and the final sign correction. With MULDIV_FAST_MUL_EN the multiply product
// is formed at load time instead of by iteration.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  // acc holds {partial product} for MUL and {remainder, quotient} for DIV
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              is_div_q, is_div_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;

  md_op_e            op;
  logic              sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [XLEN:0]     trial, diff, sum;
  logic              ge;
  logic [2*XLEN-1:0] prod;

  assign op = md_op_e'(op_i);

  // Load operands as magnitudes, then one MUL or DIV step per step_i
  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    sgn      = (op == MD_MULT) || (op == MD_DIV);
    a_neg    = sgn & a_i[XLEN-1];
    b_neg    = sgn & b_i[XLEN-1];
    a_abs    = a_neg ? -a_i : a_i;
    b_abs    = b_neg ? -b_i : b_i;
    trial    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff     = trial - {1'b0, opnd_q};
    ge       = (trial >= {1'b0, opnd_q});
    sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    if (load_i) begin
      is_div_d = (op == MD_DIV) || (op == MD_DIVU);
      if (is_div_d) begin
        acc_d    = {{XLEN{1'b0}}, a_abs};
        opnd_d   = b_abs;
        // divide by zero keeps the raw all-ones quotient
        neg_lo_d = (a_neg ^ b_neg) & (b_i != '0);
        neg_hi_d = a_neg;
      end else begin
`ifdef MULDIV_FAST_MUL_EN
        acc_d    = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
`else
        acc_d    = {{XLEN{1'b0}}, b_abs};
`endif
        opnd_d   = a_abs;
        neg_lo_d = a_neg ^ b_neg;
        neg_hi_d = 1'b0;
      end
    end else if (step_i) begin
      if (is_div_q) begin
        acc_d = {(ge ? diff[XLEN-1:0] : trial[XLEN-1:0]), acc_q[XLEN-2:0], ge};
      end else begin
        acc_d = {sum, acc_q[XLEN-1:1]};
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end

  // Sign correction of the magnitude result
  always_comb begin
    prod = neg_lo_q ? -acc_q : acc_q;
    if (is_div_q) begin
      lo_o = neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      hi_o = neg_hi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end else begin
      lo_o = prod[XLEN-1:0];
      hi_o = prod[2*XLEN-1:XLEN];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit for the EX stage: sequencing FSM, HI/LO registers
// and the stall request to the hazard logic. MULDIV_FAST_MUL_EN makes
// MULT/MULTU complete in one cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = muldiv_pkg::XLEN,
  parameter int unsigned CNT_W = muldiv_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start_EX,
  input  logic [1:0]      Op_EX,
  input  logic [XLEN-1:0] SrcA_EX,
  input  logic [XLEN-1:0] SrcB_EX,
  input  logic            HiWe_EX,
  input  logic            LoWe_EX,
  input  logic            Mf_ID,
  input  logic            Cancel,
  output logic            Busy,
  output logic            Stall_Req,
  output logic            Done,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             core_load, core_step;
  logic [XLEN-1:0]  core_hi, core_lo;

  assign core_load = (state_q == S_IDLE) & Start_EX;
  assign core_step = (state_q == S_RUN) & ~Cancel;

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (core_load),
    .step_i (core_step),
    .op_i   (Op_EX),
    .a_i    (SrcA_EX),
    .b_i    (SrcB_EX),
    .hi_o   (core_hi),
    .lo_o   (core_lo)
  );

  // Next-state, iteration count, HI/LO write selection and Done
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start_EX) begin
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef MULDIV_FAST_MUL_EN
          if (!Op_EX[1]) state_d = S_FIX;
`endif
        end else begin
          if (HiWe_EX) hi_d = SrcA_EX;
          if (LoWe_EX) lo_d = SrcA_EX;
        end
      end
      S_RUN: begin
        if (Cancel) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!Cancel) begin
          hi_d   = core_hi;
          lo_d   = core_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Stall_Req = Busy & Mf_ID;
  assign Done      = done_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule
